// File: rtl/pitch_sched.sv
// Voice pitch scheduler: arbitrates per-frame lookups of a shared pitch ROM
// across four voices and converts each ROM word into a phase increment.
module pitch_sched #(
  parameter int SAMPLE_RATE = 16384,
  parameter int SLOTS       = 4,
  localparam int W          = $clog2(SAMPLE_RATE)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           sample_ena,
  input  logic [3:0]     req,
  input  logic [15:0]    notes,
  output logic [3:0]     rom_addr,
  input  logic [W-1:0]   rom_data,
  output logic [4*W-1:0] inc,
  output logic [3:0]     upd,
  output logic           busy,
  output logic           frame_done,
  output logic           overrun
);

  localparam logic [1:0]   IDLE    = 2'd0;
  localparam logic [1:0]   ARB     = 2'd1;
  localparam logic [1:0]   LOOK    = 2'd2;
  localparam logic [2:0]   SLOTS_C = 3'(SLOTS);
  localparam logic [W-1:0] RATE_C  = W'(SAMPLE_RATE);

  logic [1:0]   state_r;
  logic [3:0]   pend_r;
  logic [1:0]   ptr_r;
  logic [2:0]   cnt_r;
  logic [1:0]   vsel_r;
  logic [W-1:0] inc_r [4];

  logic         pick_ok_s;
  logic [1:0]   pick_s;
  logic [3:0]   code_s;
  logic [W-1:0] look_inc_s;

  assign inc = {inc_r[3], inc_r[2], inc_r[1], inc_r[0]};

  // Rotating priority pick: scan from the far end so the voice nearest ptr wins.
  always_comb begin
    pick_ok_s = |pend_r;
    pick_s    = ptr_r;
    for (int i = 3; i >= 0; i--) begin
      pick_s = pend_r[ptr_r + 2'(i)] ? (ptr_r + 2'(i)) : pick_s;
    end
    code_s = notes[{pick_s, 2'b00} +: 4];
  end

  // rom_addr still holds the granted note code while in LOOK; code 0 means silence.
  always_comb begin
    look_inc_s = (rom_addr == 4'd0) ? {W{1'b0}} : (RATE_C - rom_data);
  end

  // Frame sequencer and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      pend_r     <= 4'd0;
      ptr_r      <= 2'd0;
      cnt_r      <= 3'd0;
      vsel_r     <= 2'd0;
      rom_addr   <= 4'd0;
      upd        <= 4'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int v = 0; v < 4; v++) begin
        inc_r[v] <= {W{1'b0}};
      end
    end else begin
      upd        <= 4'd0;
      frame_done <= 1'b0;
      overrun    <= sample_ena & (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (sample_ena) begin
            pend_r  <= req;
            cnt_r   <= 3'd0;
            busy    <= 1'b1;
            state_r <= ARB;
          end
        end
        ARB: begin
          if (!pick_ok_s || (cnt_r == SLOTS_C)) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state_r    <= IDLE;
          end else begin
            rom_addr <= code_s;
            vsel_r   <= pick_s;
            state_r  <= LOOK;
          end
        end
        LOOK: begin
          inc_r[vsel_r]  <= look_inc_s;
          pend_r[vsel_r] <= 1'b0;
          upd            <= 4'd1 << vsel_r;
          ptr_r          <= vsel_r + 2'd1;
          cnt_r          <= cnt_r + 3'd1;
          state_r        <= ARB;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_sched.sv
// Bench for pitch_sched: two instances (4 and 2 lookup slots) checked every
// cycle against a frame-schedule reference model, plus directed scenarios.
module tb_pitch_sched;

  localparam int W = 14;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_ena = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [15:0] notes = 16'd0;

  logic [3:0]     rom_addr4, rom_addr2;
  logic [W-1:0]   rom_data4, rom_data2;
  logic [4*W-1:0] inc4, inc2;
  logic [3:0]     upd4, upd2;
  logic           busy4, busy2, fd4, fd2, ov4, ov2;

  logic [W-1:0] rom_tbl [16];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign rom_data4 = rom_tbl[rom_addr4];
  assign rom_data2 = rom_tbl[rom_addr2];

  pitch_sched #(.SAMPLE_RATE(16384), .SLOTS(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .sample_ena(sample_ena), .req(req),
    .notes(notes), .rom_addr(rom_addr4), .rom_data(rom_data4), .inc(inc4),
    .upd(upd4), .busy(busy4), .frame_done(fd4), .overrun(ov4));

  pitch_sched #(.SAMPLE_RATE(16384), .SLOTS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .sample_ena(sample_ena), .req(req),
    .notes(notes), .rom_addr(rom_addr2), .rom_data(rom_data2), .inc(inc2),
    .upd(upd2), .busy(busy2), .frame_done(fd2), .overrun(ov2));

  // Reference model: a frame is a list of granted voices fixed at the strobe;
  // grant j samples its note at edge 2j+1 and updates inc at edge 2j+2.
  int         slots_m [2] = '{4, 2};
  bit         m_busy [2];
  int         m_d [2];
  int         m_n [2];
  int         m_g [2][4];
  int         m_ptr [2];
  int         m_code [2];
  logic [3:0] m_addr [2];
  logic [W-1:0] m_inc [2][4];
  logic [3:0] e_upd [2];
  bit         e_fd [2];
  bit         e_ov [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int v, j, n;
    e_upd[k] = 4'd0;
    e_fd[k]  = 1'b0;
    e_ov[k]  = 1'b0;
    if (!reset_n) begin
      m_busy[k] = 1'b0;
      m_ptr[k]  = 0;
      m_addr[k] = 4'd0;
      for (int i = 0; i < 4; i++) m_inc[k][i] = '0;
    end else if (!m_busy[k]) begin
      if (sample_ena) begin
        n = 0;
        for (int i = 0; i < 4; i++) begin
          v = (m_ptr[k] + i) % 4;
          if (req[v] && n < slots_m[k]) begin
            m_g[k][n] = v;
            n++;
          end
        end
        m_n[k]    = n;
        m_d[k]    = 0;
        m_busy[k] = 1'b1;
      end
    end else begin
      e_ov[k] = sample_ena;
      m_d[k]++;
      if (m_d[k] == 2 * m_n[k] + 1) begin
        e_fd[k]   = 1'b1;
        m_busy[k] = 1'b0;
      end else if (m_d[k] % 2 == 1) begin
        j = (m_d[k] - 1) / 2;
        m_code[k] = int'(notes[4*m_g[k][j] +: 4]);
        m_addr[k] = 4'(m_code[k]);
      end else begin
        j = (m_d[k] - 2) / 2;
        v = m_g[k][j];
        m_inc[k][v] = (m_code[k] == 0) ? '0 : W'(16384 - int'(rom_tbl[m_code[k]]));
        e_upd[k][v] = 1'b1;
        m_ptr[k] = (v + 1) % 4;
      end
    end
  endtask

  task automatic compare_all();
    check("upd4", upd4, e_upd[0]);
    check("inc4", inc4, {m_inc[0][3], m_inc[0][2], m_inc[0][1], m_inc[0][0]});
    check("busy4", busy4, m_busy[0]);
    check("frame_done4", fd4, e_fd[0]);
    check("overrun4", ov4, e_ov[0]);
    check("rom_addr4", rom_addr4, m_addr[0]);
    check("upd2", upd2, e_upd[1]);
    check("inc2", inc2, {m_inc[1][3], m_inc[1][2], m_inc[1][1], m_inc[1][0]});
    check("busy2", busy2, m_busy[1]);
    check("frame_done2", fd2, e_fd[1]);
    check("overrun2", ov2, e_ov[1]);
    check("rom_addr2", rom_addr2, m_addr[1]);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sample_ena = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b1;
    sample_ena = 1'b0;
  endtask

  int q_grant[$];

  initial begin
    rom_tbl = '{14'd500, 14'd277, 14'd293, 14'd311, 14'd330, 14'd369, 14'd392, 14'd415,
                14'd440, 14'd466, 14'd494, 14'd523, 14'd554, 14'd587, 14'd622, 14'd659};
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_ptr[k] = 0; m_addr[k] = 4'd0; m_code[k] = 0; m_n[k] = 0; m_d[k] = 0;
      e_upd[k] = 4'd0; e_fd[k] = 1'b0; e_ov[k] = 1'b0;
      for (int i = 0; i < 4; i++) m_inc[k][i] = '0;
    end

    // Reset with a strobe present: strobe ignored
    do_reset();
    check("rst_busy", busy4, 1'b0);
    check("rst_inc", inc4, 56'd0);

    // Single lookup
    req = 4'b0001; notes = 16'h0001; sample_ena = 1'b1;
    cyc();
    sample_ena = 1'b0;
    cyc();
    cyc();
    check("single_inc0", inc4[13:0], 14'd16107);
    check("single_upd", upd4, 4'b0001);
    cyc();
    check("single_done", fd4, 1'b1);

    // Silence: code 0 clears inc0, upd still pulses
    notes = 16'h0000; sample_ena = 1'b1;
    cyc();
    sample_ena = 1'b0;
    cyc();
    cyc();
    check("silence_inc0", inc4[13:0], 14'd0);
    check("silence_upd", upd4, 4'b0001);
    cyc();

    // Full frame with overrun strobe at the third edge after the frame start
    do_reset();
    req = 4'b1111; notes = 16'h5431; sample_ena = 1'b1;
    cyc();
    sample_ena = 1'b0;
    cyc();
    cyc();
    sample_ena = 1'b1;
    cyc();
    check("overrun_pulse", ov4, 1'b1);
    sample_ena = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    check("full_done", fd4, 1'b1);
    check("full_inc", inc4, {14'd16015, 14'd16054, 14'd16073, 14'd16107});

    // Budget: SLOTS=2 instance, three frames with all voices requesting
    do_reset();
    q_grant.delete();
    for (int f = 0; f < 3; f++) begin
      sample_ena = 1'b1;
      cyc();
      sample_ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
        cyc();
        for (int v = 0; v < 4; v++) if (upd2[v]) q_grant.push_back(v);
      end
    end
    check("budget_count", q_grant.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("budget_grant", (i < q_grant.size()) ? q_grant[i] : -1, (i % 4 == 0 || i % 4 == 2) ? (i % 4) : (i % 4));
    end

    // Reset during LOOK, then a fresh frame starts at voice 0
    req = 4'b1111; notes = 16'h9876; sample_ena = 1'b1;
    cyc();
    sample_ena = 1'b0;
    cyc();
    reset_n = 1'b0;
    cyc();
    check("midrst_busy", busy4, 1'b0);
    check("midrst_inc", inc4, 56'd0);
    check("midrst_addr", rom_addr4, 4'd0);
    reset_n = 1'b1; sample_ena = 1'b1;
    cyc();
    sample_ena = 1'b0;
    cyc();
    cyc();
    check("midrst_first", upd4, 4'b0001);
    for (int i = 0; i < 8; i++) cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 99) != 0);
      sample_ena = ($urandom_range(0, 3) == 0);
      req        = 4'($urandom);
      notes      = 16'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pitch_sched.md
PITCH_SCHED -- requirements
Module: pitch_sched

Interface
REQ-001 SHALL have parameter SAMPLE_RATE, default 16384, the sample rate; W = clog2(SAMPLE_RATE) (14 at default).
REQ-002 SHALL have parameter SLOTS, default 4, legal range 1..4, the maximum number of ROM lookups per sample frame.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port sample_ena, input, 1 bit, single-cycle frame strobe.
REQ-006 SHALL have port req, input, 4 bits, per-voice lookup request (bit v = voice v).
REQ-007 SHALL have port notes, input, 16 bits, per-voice note code, voice v on bits [4v+3:4v].
REQ-008 SHALL have port rom_addr, output, 4 bits, registered address to the shared combinational pitch ROM.
REQ-009 SHALL have port rom_data, input, W bits, ROM output for the current rom_addr.
REQ-010 SHALL have port inc, output, 4*W bits, per-voice phase increment, voice v on bits [W*v+W-1:W*v], registered.
REQ-011 SHALL have port upd, output, 4 bits, one-cycle pulse per voice when its inc field changes.
REQ-012 SHALL have ports busy (1 bit), frame_done (1-cycle pulse) and overrun (1-cycle pulse), all outputs.

Function
REQ-013 SHALL run a three-state FSM: IDLE, ARB and LOOK.
REQ-014 In IDLE with sample_ena=1, SHALL latch pend <= req, clear the lookup counter and go to ARB; req and notes changes after this edge do not affect pend.
REQ-015 In ARB, SHALL pick the lowest-rotation voice v with pend[v]=1, searching from ptr upward modulo 4.
REQ-016 In ARB, on a successful pick, SHALL drive rom_addr <= notes[v] (sampled in ARB), store v and go to LOOK.
REQ-017 In ARB, when no bit of pend is set or the counter equals SLOTS, SHALL return to IDLE and pulse frame_done.
REQ-018 In LOOK, SHALL set inc[v] <= SAMPLE_RATE - rom_data, truncated to W bits; when the stored note code is 0, inc[v] SHALL instead be 0 (silence).
REQ-019 In LOOK, SHALL also clear pend[v], pulse upd[v], set ptr <= (v+1) mod 4, increment the counter and return to ARB.
REQ-020 Each lookup SHALL take exactly 2 cycles (ARB, LOOK); a frame with N grants SHALL end with frame_done N*2+1 cycles after the sample_ena edge.
REQ-021 Voices left pending when the budget is exhausted SHALL be dropped for that frame; since ptr rotates, no requesting voice SHALL starve across frames.
REQ-022 busy SHALL be 1 in ARB and LOOK and 0 in IDLE.
REQ-023 sample_ena while busy SHALL be ignored, and overrun SHALL pulse high for that cycle.
REQ-024 inc fields of voices not granted SHALL hold their values; at most one upd bit SHALL be high in any cycle.
REQ-025 rom_addr SHALL hold its last value outside ARB.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force IDLE, pend=0, ptr=0, counter=0, rom_addr=0, inc=0, upd=0, busy=0, frame_done=0 and overrun=0, including mid-frame.
REQ-027 sample_ena in the same cycle as reset_n=0 SHALL be ignored.

Verification
REQ-028 Scenario, single lookup: SLOTS=4, ROM maps 1->277; req=0001 with notes[3:0]=1 and a sample_ena pulse -> inc0=16107 and upd=0001 two cycles after the strobe edge; frame_done one cycle later.
REQ-029 Scenario, full frame: req=1111 with codes 1,3,4,5 (ROM 277,311,330,369) -> upd pulses voices 0,1,2,3 on alternate cycles; inc=16107,16073,16054,16015; busy high 8 cycles.
REQ-030 Scenario, budget: SLOTS=2, req=1111 held for 3 frames -> grants are voices 0,1 then 2,3 then 0,1, with no voice starved.
REQ-031 Scenario, silence: note code 0 with req set -> inc cleared to 0 and upd still pulses.
REQ-032 Scenario, overrun: sample_ena reasserted 3 cycles into a 4-voice frame -> overrun=1 for that cycle and the frame completes unchanged.
REQ-033 Scenario, reset mid-frame: reset_n=0 during LOOK -> next cycle all outputs 0 and IDLE; a later strobe starts a fresh frame from voice 0.
